game_controller: RTL
====================

# game_controller

Sequencing controller for the tic-tac-toe datapath. It takes decoded keypad presses and owns the 18-bit board register, so keypad handling, board writes, turn alternation, win/draw detection and the return to the main screen live in one FSM. The display blocks (7-segment P1/P2 text and the dot-matrix renderer) are pure consumers of its outputs.

## Interface
Parameters:
- HOLD_CYCLES, default 25_000_000: number of clk cycles the result screen ignores keys before accepting a return key.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- key_valid  input  1  one-cycle pulse: key_data is valid this cycle.
- key_data  input  4  keypad code; 1..9 select cells, all other codes are non-cell keys.
- board  output  18  board state. Cell k (1..9) uses bit 18-2k for a P1 mark and bit 19-2k for a P2 mark.
- is_main  output  1  high in MAIN state.
- is_turn_o  output  1  0 means P1 to move, 1 means P2 to move.
- winner  output  2  00 none, 01 P1, 10 P2, 11 draw. Valid in RESULT.
- win_line  output  8  one bit per winning line. Bit order is: rows 1-2-3, 4-5-6, 7-8-9; columns 1-4-7, 2-5-8, 3-6-9; diagonals 1-5-9, 3-5-7 (bit0..bit7).
- move_count  output  4  marks placed so far, 0..9.
- err  output  1  one-cycle pulse when a key press in PLAY is rejected.

## Operation
States are MAIN, PLAY, CHECK and RESULT.

- **MAIN**
  - board=0, is_turn_o=0, move_count=0, winner=00, win_line=0, is_main=1.
  - Any key_valid moves the FSM to PLAY. That key is consumed and places no mark.
- **PLAY** (is_main=0)
  - On key_valid with key_data in 1..9 and both bits of that cell clear:
    - set bit 18-2k+is_turn_o;
    - move_count += 1;
    - go to CHECK.
  - On key_valid with key_data 0 or 10..15, or with an occupied cell: pulse err for one cycle, leave the board unchanged, stay in PLAY.
- **CHECK** (exactly one cycle)
  - Evaluate the 8 lines against the current player's mark bits only.
  - If any line is complete: winner = 01 when is_turn_o=0, or 10 when is_turn_o=1; win_line = the set of completed lines (several bits may be set); go to RESULT.
  - Else if move_count==9: winner=11, win_line=0, go to RESULT.
  - Else: toggle is_turn_o, go to PLAY.
  - key_valid during CHECK is dropped: no board change, no err.
- **RESULT**
  - The board is frozen and is_turn_o holds the last mover.
  - The hold counter loads 0 on entry and increments each cycle, saturating at HOLD_CYCLES.
  - While the counter is below HOLD_CYCLES, key_valid is ignored.
  - Once the counter reaches HOLD_CYCLES, the next key_valid returns the FSM to MAIN, and all game state clears on that edge.
- A win on the 9th move reports the win (01/10), not a draw.

## Timing
- Reset values: state=MAIN, board=0, is_main=1, is_turn_o=0, winner=00, win_line=0, move_count=0, err=0, hold counter=0.
- Reset asserted mid-game returns everything to these values immediately (asynchronous), regardless of state.
- All outputs are registered.
- For a key accepted at rising edge N:
  - board and move_count update at edge N;
  - the CHECK result (winner, win_line, is_turn_o toggle or RESULT entry) is visible after edge N+1.
- err is high for exactly the one cycle following the rejecting edge.
- Minimum spacing between accepted moves is 2 cycles. A key arriving one cycle after an accepted key lands in CHECK and is lost.
- With HOLD_CYCLES=H and RESULT entered at edge R, the first key that can return to MAIN is sampled at edge R+H.
- The hold counter is 25 bits wide, which is sufficient for the default.

## Test plan
- **Reset:** assert rst mid-PLAY with board≠0 -> all outputs at reset values while rst is high; is_main=1 after release.
- **P1 row win:** key 5 (start), then 1,4,2,5,3, each one per 4 cycles -> board=18'h15A00, winner=01, win_line=8'h01, move_count=5, is_turn_o=0.
- **Occupied cell:** start, key 5, then key 5 again -> err pulses one cycle, board unchanged (bit 8 only), is_turn_o stays 1. Key 0 also gives err.
- **Draw:** start, then 1,2,3,5,4,6,8,7,9 -> winner=11, win_line=0, move_count=9. P1 bits are set for cells 1,3,4,8,9 and P2 bits for cells 2,5,6,7.
- **Dropped key in CHECK:** key 1 accepted, then key 2 on the very next cycle -> only cell 1 marked, no err, P2 to move.
- **Result hold (HOLD_CYCLES=8):**
  - key at R+3 -> ignored;
  - key at R+8 -> MAIN with board=0 and winner=00.

Source files
------------

// File: rtl/game_controller.sv
// Tic-tac-toe sequencing FSM: keypad moves, board register, turn order,
// win/draw detection and the timed return to the main screen.
module game_controller #(
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_data,
  output logic [17:0] board,
  output logic        is_main,
  output logic        is_turn_o,
  output logic [1:0]  winner,
  output logic [7:0]  win_line,
  output logic [3:0]  move_count,
  output logic        err
);

  localparam logic [1:0] S_MAIN   = 2'd0;
  localparam logic [1:0] S_PLAY   = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  // Cell masks over marks[8:0] (bit k-1 = cell k), in win_line bit order.
  localparam logic [7:0][8:0] LINES = {9'h054, 9'h111, 9'h124, 9'h092,
                                       9'h049, 9'h1C0, 9'h038, 9'h007};

  logic [1:0]  state;
  logic [24:0] hold_cnt;
  logic [8:0]  marks;
  logic [15:0] key_occ;
  logic [7:0]  line_hit;
  logic [4:0]  set_pos;
  logic        hold_done;

  // Non-cell codes read as occupied so one lookup rejects both cases.
  assign key_occ[0] = 1'b1;
  assign key_occ[15:10] = '1;

  genvar k;
  generate
    for (k = 0; k < 9; k++) begin : g_cell
      assign marks[k]     = is_turn_o ? board[17-2*k] : board[16-2*k];
      assign key_occ[k+1] = board[17-2*k] | board[16-2*k];
    end
    for (k = 0; k < 8; k++) begin : g_line
      assign line_hit[k] = (marks & LINES[k]) == LINES[k];
    end
  endgenerate

  assign set_pos   = 5'd18 - {key_data, 1'b0} + {4'd0, is_turn_o};
  // Compare against the post-increment count so a key at R+HOLD is taken.
  assign hold_done = ({1'b0, hold_cnt} + 26'd1) >= 26'(HOLD_CYCLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_MAIN;
      board      <= '0;
      is_main    <= 1'b1;
      is_turn_o  <= 1'b0;
      winner     <= 2'b00;
      win_line   <= '0;
      move_count <= '0;
      err        <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_MAIN: begin
          if (key_valid) begin
            state   <= S_PLAY;
            is_main <= 1'b0;
          end
        end
        S_PLAY: begin
          if (key_valid) begin
            if (!key_occ[key_data]) begin
              board      <= board | (18'd1 << set_pos);
              move_count <= move_count + 4'd1;
              state      <= S_CHECK;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (|line_hit) begin
            winner   <= is_turn_o ? 2'b10 : 2'b01;
            win_line <= line_hit;
            hold_cnt <= '0;
            state    <= S_RESULT;
          end else if (move_count == 4'd9) begin
            winner   <= 2'b11;
            win_line <= '0;
            hold_cnt <= '0;
            state    <= S_RESULT;
          end else begin
            is_turn_o <= ~is_turn_o;
            state     <= S_PLAY;
          end
        end
        default: begin
          if ({1'b0, hold_cnt} < 26'(HOLD_CYCLES))
            hold_cnt <= hold_cnt + 25'd1;
          if (key_valid && hold_done) begin
            state      <= S_MAIN;
            board      <= '0;
            is_main    <= 1'b1;
            is_turn_o  <= 1'b0;
            winner     <= 2'b00;
            win_line   <= '0;
            move_count <= '0;
            hold_cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule
